// File: rtl/thunderbird_pkg.sv
// Shared types and constants for the Thunderbird tail-light sequencer:
// state encoding, lamp bit positions and the lamp pattern of every state.
package thunderbird_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_L1   = 3'd1,
    ST_L2   = 3'd2,
    ST_L3   = 3'd3,
    ST_R1   = 3'd4,
    ST_R2   = 3'd5,
    ST_R3   = 3'd6,
    ST_HAZ  = 3'd7
  } state_t;

  // Lamp bit positions; LA and RA are the innermost lamps.
  localparam int LAMP_RC = 0;
  localparam int LAMP_RB = 1;
  localparam int LAMP_RA = 2;
  localparam int LAMP_LA = 3;
  localparam int LAMP_LB = 4;
  localparam int LAMP_LC = 5;

  localparam logic [5:0] PAT_IDLE = 6'b000000;
  localparam logic [5:0] PAT_L1   = 6'b001000;
  localparam logic [5:0] PAT_L2   = 6'b011000;
  localparam logic [5:0] PAT_L3   = 6'b111000;
  localparam logic [5:0] PAT_R1   = 6'b000100;
  localparam logic [5:0] PAT_R2   = 6'b000110;
  localparam logic [5:0] PAT_R3   = 6'b000111;
  localparam logic [5:0] PAT_HAZ  = 6'b111111;

  function automatic logic [5:0] lamp_pattern(input state_t s);
    case (s)
      ST_L1:   return PAT_L1;
      ST_L2:   return PAT_L2;
      ST_L3:   return PAT_L3;
      ST_R1:   return PAT_R1;
      ST_R2:   return PAT_R2;
      ST_R3:   return PAT_R3;
      ST_HAZ:  return PAT_HAZ;
      default: return PAT_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/thunderbird_tick_gen.sv
// Step prescaler: free-running 0..TICK_DIV-1 counter with a strobe in the
// last count. With TICK_DIV=1 the strobe is permanently high.
module thunderbird_tick_gen #(
  parameter int TICK_DIV = 50_000_000,
  parameter int CNT_W    = $clog2(TICK_DIV + 1)
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             w_last;

  assign w_last = (r_cnt == LAST);
  assign tick   = w_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_last) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/thunderbird_seq_ctrl.sv
// Thunderbird tail-light sequencer: synchronizes the three switch requests,
// arbitrates them and walks the lamp FSM one step per prescaler tick.
module thunderbird_seq_ctrl
  import thunderbird_pkg::*;
#(
  parameter int TICK_DIV = 50_000_000,
  parameter int CNT_W    = $clog2(TICK_DIV + 1)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_left,
  input  logic       req_right,
  input  logic       req_haz,
  output logic [5:0] lamps,
  output logic       active,
  output logic       tick,
  output logic [2:0] dbg_state
);

  // Synchronizer bit order: {haz, right, left}.
  logic [2:0] r_sync1;
  logic [2:0] r_sync2;
  logic       w_left_s;
  logic       w_right_s;
  logic       w_haz_eff;
  logic       w_tick;
  state_t     r_state;
  state_t     w_state_nxt;
  logic [5:0] r_lamps;
  logic       r_active;

  thunderbird_tick_gen #(
    .TICK_DIV(TICK_DIV),
    .CNT_W   (CNT_W)
  ) u_tick_gen (
    .clk  (clk),
    .rst_n(rst_n),
    .tick (w_tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= {req_haz, req_right, req_left};
      r_sync2 <= r_sync1;
    end
  end

  assign w_left_s  = r_sync2[0];
  assign w_right_s = r_sync2[1];
  // Both turn switches at once behave exactly like the hazard switch.
  assign w_haz_eff = r_sync2[2] | (w_left_s & w_right_s);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_tick) begin
      if (r_state != ST_HAZ && w_haz_eff) begin
        w_state_nxt = ST_HAZ;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (w_left_s)       w_state_nxt = ST_L1;
            else if (w_right_s) w_state_nxt = ST_R1;
            else                w_state_nxt = ST_IDLE;
          end
          ST_L1:   w_state_nxt = w_left_s  ? ST_L2 : ST_IDLE;
          ST_L2:   w_state_nxt = w_left_s  ? ST_L3 : ST_IDLE;
          ST_R1:   w_state_nxt = w_right_s ? ST_R2 : ST_IDLE;
          ST_R2:   w_state_nxt = w_right_s ? ST_R3 : ST_IDLE;
          // L3, R3 and HAZ always fall back to a dark IDLE step.
          default: w_state_nxt = ST_IDLE;
        endcase
      end
    end
  end

  // Outputs come from the next-state decode so they change with the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lamps  <= PAT_IDLE;
      r_active <= 1'b0;
    end else begin
      r_lamps  <= lamp_pattern(w_state_nxt);
      r_active <= (w_state_nxt != ST_IDLE);
    end
  end

  assign lamps     = r_lamps;
  assign active    = r_active;
  assign tick      = w_tick;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_thunderbird_seq_ctrl.sv
// Directed bench for thunderbird_seq_ctrl: a TICK_DIV=4 instance for the
// main scenarios and a TICK_DIV=1 instance for the every-cycle case.
module tb_thunderbird_seq_ctrl;

  logic       clk;
  logic       rst_n;
  logic       req_left, req_right, req_haz;
  logic [5:0] lamps;
  logic       active, tick;
  logic [2:0] dbg_state;
  logic       req_left1;
  logic [5:0] lamps1;
  logic       active1, tick1;
  logic [2:0] dbg_state1;

  int n_checks = 0;
  int n_errors = 0;
  int edge_no  = 0;
  logic [5:0] exp_q[$];

  thunderbird_seq_ctrl #(.TICK_DIV(4)) dut4 (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_left (req_left),
    .req_right(req_right),
    .req_haz  (req_haz),
    .lamps    (lamps),
    .active   (active),
    .tick     (tick),
    .dbg_state(dbg_state)
  );

  thunderbird_seq_ctrl #(.TICK_DIV(1)) dut1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_left (req_left1),
    .req_right(1'b0),
    .req_haz  (1'b0),
    .lamps    (lamps1),
    .active   (active1),
    .tick     (tick1),
    .dbg_state(dbg_state1)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Driver tasks
  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask

  // Edge k is the k-th rising edge after reset release; checks happen at
  // the falling edge following it.
  task automatic goto_edge(input int k);
    while (edge_no < k) begin
      @(negedge clk);
      edge_no++;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n   = 1'b1;
    edge_no = 0;
  endtask

  initial begin
    logic [5:0] prev_pat;
    int         sweep_edge[5];
    logic [5:0] sweep_pat[5];
    sweep_edge = '{4, 8, 12, 16, 20};
    sweep_pat  = '{6'b001000, 6'b011000, 6'b111000, 6'b000000, 6'b001000};

    rst_n = 1'b1;
    req_left = 1'b0; req_right = 1'b0; req_haz = 1'b0; req_left1 = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check_eq("rst_lamps", lamps, 6'b000000);
    check_eq("rst_active", active, 1'b0);
    check_eq("rst_tick", tick, 1'b0);
    check_eq("rst_state", dbg_state, 3'd0);
    check_eq("rst_lamps1", lamps1, 6'b000000);

    // Hazard running, then async reset in the middle of a step
    req_haz = 1'b1;
    @(negedge clk);
    rst_n = 1'b1; edge_no = 0;
    goto_edge(4);
    check_eq("haz_lamps", lamps, 6'b111111);
    check_eq("haz_active", active, 1'b1);
    check_eq("haz_state", dbg_state, 3'd7);
    goto_edge(5);
    rst_n = 1'b0;
    #1;
    check_eq("async_rst_lamps", lamps, 6'b000000);
    check_eq("async_rst_active", active, 1'b0);
    check_eq("async_rst_tick", tick, 1'b0);

    // Left sweep straight out of reset
    req_haz = 1'b0; req_left = 1'b1;
    @(negedge clk);
    rst_n = 1'b1; edge_no = 0;
    goto_edge(2);
    check_eq("first_tick_early", tick, 1'b0);
    goto_edge(3);
    check_eq("first_tick", tick, 1'b1);
    check_eq("pre_tick_lamps", lamps, 6'b000000);
    for (int i = 0; i < 5; i++) exp_q.push_back(sweep_pat[i]);
    prev_pat = 6'b000000;
    for (int i = 0; i < 5; i++) begin
      logic [5:0] exp_pat;
      goto_edge(sweep_edge[i] - 1);
      check_eq("left_hold", lamps, prev_pat);
      goto_edge(sweep_edge[i]);
      exp_pat = exp_q.pop_front();
      check_eq("left_step", lamps, exp_pat);
      check_eq("left_active", active, exp_pat != 6'b000000);
      prev_pat = exp_pat;
    end

    // Both turn switches together flash like hazards
    req_left = 1'b1; req_right = 1'b1;
    do_reset();
    goto_edge(4);  check_eq("both_on1", lamps, 6'b111111);
    goto_edge(6);  check_eq("both_hold", lamps, 6'b111111);
    goto_edge(8);  check_eq("both_off1", lamps, 6'b000000);
    goto_edge(12); check_eq("both_on2", lamps, 6'b111111);
    goto_edge(16); check_eq("both_off2", lamps, 6'b000000);

    // Early release of the right switch during R2
    req_left = 1'b0; req_right = 1'b1;
    do_reset();
    goto_edge(4);  check_eq("right_r1", lamps, 6'b000100);
    goto_edge(8);  check_eq("right_r2", lamps, 6'b000110);
    goto_edge(9);
    req_right = 1'b0;
    goto_edge(11); check_eq("early_hold", lamps, 6'b000110);
    goto_edge(12); check_eq("early_idle", lamps, 6'b000000);
    check_eq("early_active", active, 1'b0);
    goto_edge(20); check_eq("early_stay", lamps, 6'b000000);

    // Hazard preempting R1, with enough time to synchronize
    req_right = 1'b1;
    do_reset();
    goto_edge(4);  check_eq("pre_r1", lamps, 6'b000100);
    goto_edge(5);
    req_haz = 1'b1;
    goto_edge(7);  check_eq("pre_hold", lamps, 6'b000100);
    goto_edge(8);  check_eq("pre_haz", lamps, 6'b111111);

    // Hazard one cycle too late for the tick: seen a full step later
    req_haz = 1'b0;
    do_reset();
    goto_edge(6);
    req_haz = 1'b1;
    goto_edge(8);  check_eq("late_r2", lamps, 6'b000110);
    goto_edge(12); check_eq("late_haz", lamps, 6'b111111);
    goto_edge(16); check_eq("late_off", lamps, 6'b000000);
    goto_edge(20); check_eq("late_on", lamps, 6'b111111);

    // A request pulse between ticks is ignored
    req_haz = 1'b0; req_right = 1'b0;
    do_reset();
    goto_edge(4);  check_eq("glitch_idle", lamps, 6'b000000);
    req_left = 1'b1;
    goto_edge(5);
    req_left = 1'b0;
    goto_edge(8);  check_eq("glitch_ignored", lamps, 6'b000000);
    check_eq("glitch_active", active, 1'b0);
    goto_edge(12); check_eq("glitch_still", lamps, 6'b000000);

    // TICK_DIV=1: one step per cycle, first change on the third edge
    do_reset();
    goto_edge(2);
    check_eq("div1_tick", tick1, 1'b1);
    req_left1 = 1'b1;
    goto_edge(4);  check_eq("div1_wait", lamps1, 6'b000000);
    goto_edge(5);  check_eq("div1_l1", lamps1, 6'b001000);
    check_eq("div1_active", active1, 1'b1);
    goto_edge(6);  check_eq("div1_l2", lamps1, 6'b011000);
    goto_edge(7);  check_eq("div1_l3", lamps1, 6'b111000);
    goto_edge(8);  check_eq("div1_idle", lamps1, 6'b000000);
    check_eq("div1_state", dbg_state1, 3'd0);
    goto_edge(9);  check_eq("div1_l1_again", lamps1, 6'b001000);

    // Final report
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
